wb4_fifo_reader: RTL and testbench

WB4_FIFO_READER -- requirements
Module: wb4_fifo_reader

---
 rtl/wb4_fifo_pkg.sv | 16 +
 rtl/wb4_fifo_reader_rbuf.sv | 79 +++++++
 rtl/wb4_fifo_reader.sv | 124 ++++++++++++
 tb/tb_wb4_fifo_reader.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb4_fifo_pkg.sv
// Shared definitions for the WB4 FIFO reader: FSM encodings and credit sizing.
// Latency: n/a (constants and a constant function only).
// Backpressure: n/a.
package wb4_fifo_pkg;

  // Read-side FSM encodings. The 2'd3 code is never entered.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;

  // Width of a counter that must hold every value 0..credits inclusive.
  function automatic int credit_width(input int credits);
    return $clog2(credits) + 1;
  endfunction

endpackage

// File: rtl/wb4_fifo_reader_rbuf.sv
// Return buffer: register-based circular FIFO holding acked read data.
// Latency: a push is visible at the head on the cycle after the push edge.
// Backpressure: push is dropped only when full with no pop; the caller's
//   credit accounting keeps that from happening.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   push, push_data  write one entry at the tail
//   pop           remove the head entry (ignored while empty)
//   head_data     current head entry (zero after reset)
//   full, empty, count  occupancy status
module wb4_fifo_reader_rbuf
  import wb4_fifo_pkg::*;
#(
  parameter int P_DATA_MSB = 7,
  parameter int P_CREDITS  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic [P_DATA_MSB:0]         push_data,
  input  logic                        pop,
  output logic [P_DATA_MSB:0]         head_data,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(P_CREDITS):0]  count
);

  localparam int PW = $clog2(P_CREDITS);
  localparam int CW = credit_width(P_CREDITS);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(P_CREDITS);

  logic [P_DATA_MSB:0] mem [P_CREDITS];
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [CW-1:0]       cnt;
  logic                do_push;
  logic                do_pop;

  assign empty = (cnt == '0);
  assign full  = (cnt == CNT_MAX);
  assign count = cnt;

  // A pop frees the head slot on the same edge, so a push into a full
  // buffer is fine when it coincides with a pop.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Head is read straight from the array: no bypass from push_data.
  assign head_data = mem[rd_ptr];

  // Pointers are PW bits wide and P_CREDITS is a power of two, so the
  // natural binary rollover gives the modulo-depth wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < P_CREDITS; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/wb4_fifo_reader.sv
// Pulls words from a WB4 FIFO read port and re-emits them as a valid/ready stream.
// Latency: ack to o_stream_valid is 1 cycle; 1 beat/cycle sustained when ack latency < P_CREDITS.
// Backpressure: requests are credit-limited so acked data always has a buffer slot.
// Ports:
//   i_clk, i_rst                 clock, asynchronous active-high reset
//   i_enable                     level; permits new read requests
//   o_wb4_out_mcyc/mstb          WB4 cycle and read strobe to the FIFO
//   i_wb4_out_mack/mdata/mstall  WB4 ack, read data, stall (FIFO empty)
//   o_stream_valid/data, i_stream_ready  downstream stream
//   o_busy                       cycle open or buffered data pending
//   o_err                        sticky; an ack arrived with nothing in flight
module wb4_fifo_reader
  import wb4_fifo_pkg::*;
#(
  parameter int P_DATA_MSB = 7,
  parameter int P_CREDITS  = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_enable,
  output logic                o_wb4_out_mcyc,
  output logic                o_wb4_out_mstb,
  input  logic                i_wb4_out_mack,
  input  logic [P_DATA_MSB:0] i_wb4_out_mdata,
  input  logic                i_wb4_out_mstall,
  output logic                o_stream_valid,
  input  logic                i_stream_ready,
  output logic [P_DATA_MSB:0] o_stream_data,
  output logic                o_busy,
  output logic                o_err
);

  localparam int CW = credit_width(P_CREDITS);
  localparam int SW = CW + 1;
  localparam logic [CW-1:0] CNT_ONE      = CW'(1);
  localparam logic [SW-1:0] CREDIT_LIMIT = SW'(P_CREDITS);

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [CW-1:0] inflight;
  logic [CW-1:0] occupancy;
  logic [SW-1:0] credits_used;
  logic          credit_ok;
  logic          accept;
  logic          ack_ok;
  logic          ack_spurious;
  logic          buf_empty;
  logic          buf_full;
  logic          pop;

  // ---------------------------------------------------------------------
  // Credit accounting: every outstanding request plus every buffered word
  // owns one slot. Summed one bit wider so the compare cannot wrap.
  // ---------------------------------------------------------------------
  assign credits_used = {1'b0, inflight} + {1'b0, occupancy};
  assign credit_ok    = (credits_used < CREDIT_LIMIT) & ~buf_full;

  assign o_wb4_out_mcyc = (state == ST_ACTIVE) || (state == ST_DRAIN);
  // Strobe stays up through stalls as long as a slot is still reserved.
  assign o_wb4_out_mstb = (state == ST_ACTIVE) && credit_ok;

  assign accept       = o_wb4_out_mstb & ~i_wb4_out_mstall;
  assign ack_ok       = i_wb4_out_mack & (inflight != '0);
  assign ack_spurious = i_wb4_out_mack & (inflight == '0);

  // ---------------------------------------------------------------------
  // Read FSM
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (i_enable) state_nxt = ST_ACTIVE;
      ST_ACTIVE: if (!i_enable) state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        // Re-enable wins over finishing the drain.
        if (i_enable)             state_nxt = ST_ACTIVE;
        else if (inflight == '0)  state_nxt = ST_IDLE;
      end
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= ST_IDLE;
      inflight <= '0;
      o_err    <= 1'b0;
    end else begin
      state <= state_nxt;
      case ({accept, ack_ok})
        2'b10:   inflight <= inflight + CNT_ONE;
        2'b01:   inflight <= inflight - CNT_ONE;
        default: inflight <= inflight;
      endcase
      // An ack with nothing outstanding is dropped and flagged until reset.
      if (ack_spurious) begin
        o_err <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Return buffer and stream side
  // ---------------------------------------------------------------------
  assign o_stream_valid = ~buf_empty;
  assign pop            = o_stream_valid & i_stream_ready;
  assign o_busy         = o_wb4_out_mcyc | ~buf_empty;

  wb4_fifo_reader_rbuf #(
    .P_DATA_MSB (P_DATA_MSB),
    .P_CREDITS  (P_CREDITS)
  ) u_rbuf (
    .clk       (i_clk),
    .rst       (i_rst),
    .push      (ack_ok),
    .push_data (i_wb4_out_mdata),
    .pop       (pop),
    .head_data (o_stream_data),
    .full      (buf_full),
    .empty     (buf_empty),
    .count     (occupancy)
  );

endmodule

// File: tb/tb_wb4_fifo_reader.sv
// Bench for wb4_fifo_reader: FIFO model with 1-cycle acks and a scoreboard.
// Expected words are queued when the model accepts a request and checked
// in order as the stream pops them.
module tb_wb4_fifo_reader;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       mcyc;
  logic       mstb;
  logic       mack;
  logic [7:0] mdata;
  logic       mstall;
  logic       svalid;
  logic       sready;
  logic [7:0] sdata;
  logic       busy;
  logic       err;

  wb4_fifo_reader #(
    .P_DATA_MSB (7),
    .P_CREDITS  (4)
  ) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_enable         (enable),
    .o_wb4_out_mcyc   (mcyc),
    .o_wb4_out_mstb   (mstb),
    .i_wb4_out_mack   (mack),
    .i_wb4_out_mdata  (mdata),
    .i_wb4_out_mstall (mstall),
    .o_stream_valid   (svalid),
    .i_stream_ready   (sready),
    .o_stream_data    (sdata),
    .o_busy           (busy),
    .o_err            (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO contents, requests awaiting ack, scoreboard of expected stream words
  logic [7:0] fifo_q[$];
  logic [7:0] pend_q[$];
  logic [7:0] exp_q[$];

  int   checks;
  int   failures;
  int   acc_cnt;
  int   pop_cnt;
  int   cyc_cnt;
  int   first_pop;
  int   last_pop;
  int   start;
  bit   hold_ack;
  bit   force_stall;
  bit   spur_pend;
  logic [7:0] spur_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Runs at the falling edge: outputs are settled, inputs set here apply
  // at the next rising edge.
  task automatic model_step();
    logic [7:0] w;
    if (rst) begin
      pend_q.delete();
      exp_q.delete();
      mack = 1'b0;
      return;
    end
    if (svalid && sready) begin
      if (exp_q.size() == 0) check("stream_extra", svalid, 1'b0);
      else                   check("stream_data", sdata, exp_q.pop_front());
      if (pop_cnt == 0) first_pop = cyc_cnt;
      last_pop = cyc_cnt;
      pop_cnt++;
    end
    // Ack side: requests accepted at the previous edge are acked now.
    if (spur_pend) begin
      mack      = 1'b1;
      mdata     = spur_data;
      spur_pend = 1'b0;
    end else if (!hold_ack && pend_q.size() > 0) begin
      mack  = 1'b1;
      mdata = pend_q.pop_front();
    end else begin
      mack  = 1'b0;
      mdata = 8'h00;
    end
    mstall = force_stall || (fifo_q.size() == 0);
    if (mstb && !mstall) begin
      w = fifo_q.pop_front();
      pend_q.push_back(w);
      exp_q.push_back(w);
      acc_cnt++;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    cyc_cnt++;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 20; n++) begin
      if (!mcyc && !busy) break;
      tick();
    end
    check("idle_reached", {30'd0, mcyc, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    checks = 0; failures = 0; acc_cnt = 0; pop_cnt = 0; cyc_cnt = 0;
    first_pop = -1; last_pop = -1; start = 0;
    hold_ack = 1'b0; force_stall = 1'b0; spur_pend = 1'b0; spur_data = 8'h00;
    rst = 1'b1; enable = 1'b0; sready = 1'b0; mack = 1'b0; mdata = 8'h00; mstall = 1'b1;

    // Reset state
    #2;
    check("rst_cyc",   mcyc,   1'b0);
    check("rst_stb",   mstb,   1'b0);
    check("rst_valid", svalid, 1'b0);
    check("rst_busy",  busy,   1'b0);
    check("rst_err",   err,    1'b0);
    check("rst_data",  sdata,  8'h00);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check("idle_cyc", mcyc, 1'b0);

    // Streaming 0x01..0x10 at full rate
    for (int i = 1; i <= 16; i++) fifo_q.push_back(8'(i));
    pop_cnt = 0; first_pop = -1; sready = 1'b1; enable = 1'b1; start = cyc_cnt;
    for (int n = 0; n < 60 && pop_cnt < 16; n++) tick();
    check("stream_count", pop_cnt, 16);
    check("stream_first", first_pop, start + 3);
    check("stream_rate",  last_pop - first_pop, 15);
    check("stream_err",   err, 1'b0);
    enable = 1'b0;
    wait_idle();

    // Backpressure: 6 words, ready low
    sready = 1'b0; acc_cnt = 0; pop_cnt = 0;
    for (int i = 1; i <= 6; i++) fifo_q.push_back(8'(i));
    enable = 1'b1;
    repeat (12) tick();
    check("bp_accepts", acc_cnt, 4);
    check("bp_stb",     mstb,   1'b0);
    check("bp_valid",   svalid, 1'b1);
    check("bp_head",    sdata,  8'h01);
    repeat (3) tick();
    check("bp_hold_valid", svalid, 1'b1);
    check("bp_hold_data",  sdata,  8'h01);
    check("bp_still_4",    acc_cnt, 4);
    sready = 1'b1;
    for (int n = 0; n < 30 && pop_cnt < 6; n++) tick();
    check("bp_total",    pop_cnt, 6);
    check("bp_sb_empty", exp_q.size(), 0);
    enable = 1'b0;
    wait_idle();

    // Stall: FIFO reports empty for 10 cycles, then one word
    force_stall = 1'b1; sready = 1'b1; pop_cnt = 0; enable = 1'b1;
    tick();
    for (int k = 0; k < 10; k++) begin
      tick();
      check("stall_stb",   mstb,   1'b1);
      check("stall_valid", svalid, 1'b0);
    end
    fifo_q.push_back(8'hA5);
    force_stall = 1'b0;
    repeat (6) tick();
    check("stall_one_word", pop_cnt, 1);
    enable = 1'b0;
    wait_idle();

    // Drain: drop enable with three requests outstanding
    hold_ack = 1'b1; sready = 1'b1; pop_cnt = 0; acc_cnt = 0;
    fifo_q.push_back(8'h71); fifo_q.push_back(8'h72); fifo_q.push_back(8'h73);
    enable = 1'b1;
    for (int n = 0; n < 20 && acc_cnt < 3; n++) tick();
    check("drain_accepts", acc_cnt, 3);
    enable = 1'b0;
    tick();
    check("drain_stb", mstb, 1'b0);
    check("drain_cyc", mcyc, 1'b1);
    hold_ack = 1'b0;
    repeat (2) tick();
    check("drain_cyc_before_last_ack", mcyc, 1'b1);
    repeat (2) tick();
    check("drain_cyc_idle", mcyc, 1'b0);
    for (int n = 0; n < 10 && pop_cnt < 3; n++) tick();
    check("drain_delivered", pop_cnt, 3);
    wait_idle();

    // Spurious ack while idle
    check("spur_pre_idle", mcyc, 1'b0);
    pop_cnt = 0; spur_data = 8'h5A; spur_pend = 1'b1;
    tick();
    check("spur_err", err, 1'b1);
    repeat (5) tick();
    check("spur_err_sticky", err,    1'b1);
    check("spur_no_valid",   svalid, 1'b0);
    check("spur_no_busy",    busy,   1'b0);
    check("spur_no_output",  pop_cnt, 0);

    // Reset mid-burst with inflight=2, occupancy=2
    hold_ack = 1'b1; sready = 1'b0; acc_cnt = 0;
    for (int i = 0; i < 6; i++) fifo_q.push_back(8'(8'h31 + i));
    enable = 1'b1;
    for (int n = 0; n < 20 && acc_cnt < 4; n++) tick();
    check("rb_accepts", acc_cnt, 4);
    hold_ack = 1'b0;
    repeat (2) tick();
    hold_ack = 1'b1;
    check("rb_valid", svalid, 1'b1);
    check("rb_head",  sdata,  8'h31);
    check("rb_stb",   mstb,   1'b0);
    fifo_q.delete();
    rst = 1'b1;
    #1;
    check("rb_rst_cyc",   mcyc,   1'b0);
    check("rb_rst_stb",   mstb,   1'b0);
    check("rb_rst_valid", svalid, 1'b0);
    check("rb_rst_busy",  busy,   1'b0);
    check("rb_rst_err",   err,    1'b0);
    check("rb_rst_data",  sdata,  8'h00);
    repeat (2) tick();
    rst = 1'b0;
    #1;
    check("rb_first_stb", mstb, 1'b0);
    tick();
    check("rb_after_err",   err,    1'b0);
    check("rb_after_valid", svalid, 1'b0);
    enable = 1'b0; hold_ack = 1'b0;
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
